// File: rtl/ka_pkg.sv
// Shared widths, FSM state encoding and a carry-less reference multiply for the
// 22-bit sequential Karatsuba multiplier.
package ka_pkg;

  localparam int OP_W   = 22;
  localparam int HALF_W = 11;
  localparam int PROD_W = 2 * OP_W - 1;
  localparam int KP_W   = 2 * HALF_W - 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MUL_LO    = 3'd1,
    MUL_HI    = 3'd2,
    MUL_MID   = 3'd3,
    MUL_FLUSH = 3'd4,
    DONE      = 3'd5
  } ka_state_e;

  // Schoolbook GF(2)[x] product, for use as a golden reference only.
  function automatic logic [PROD_W-1:0] clmul_ref(input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
    logic [PROD_W-1:0] r;
    r = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (b[i]) r = r ^ ({{(PROD_W-OP_W){1'b0}}, a} << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/KA_11bit.sv
// Combinational 11x11-bit carry-less Karatsuba multiplier: one level split into
// a 6-bit low half and a 5-bit high half (zero-padded to 6 bits for the mid term).
module KA_11bit (
  input  logic [10:0] a,
  input  logic [10:0] b,
  output logic [20:0] p
);

  function automatic logic [10:0] clmul6(input logic [5:0] x, input logic [5:0] z);
    logic [10:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      if (z[i]) r = r ^ ({5'b0, x} << i);
    end
    return r;
  endfunction

  logic [5:0]  a_lo, b_lo, a_hi, b_hi;
  logic [10:0] p_lo, p_hi, p_mid;
  logic [20:0] p_lo_ext, p_hi_ext, p_mid_ext;

  assign a_lo = a[5:0];
  assign b_lo = b[5:0];
  assign a_hi = {1'b0, a[10:6]};
  assign b_hi = {1'b0, b[10:6]};

  assign p_lo  = clmul6(a_lo, b_lo);
  assign p_hi  = clmul6(a_hi, b_hi);
  assign p_mid = clmul6(a_lo ^ a_hi, b_lo ^ b_hi);

  assign p_lo_ext  = {10'b0, p_lo};
  assign p_hi_ext  = {10'b0, p_hi};
  assign p_mid_ext = {10'b0, p_mid};

  // The 5-bit high half keeps p_hi within 9 bits, so p_hi<<12 never overflows bit 20.
  assign p = p_lo_ext ^ ((p_lo_ext ^ p_mid_ext ^ p_hi_ext) << 6) ^ (p_hi_ext << 12);

endmodule

// File: rtl/ka22_accum.sv
// Product accumulator: XOR-folds each 21-bit partial product into a 43-bit acc
// according to which Karatsuba term it is. KA22_OUTREG_EN registers the core
// output first, so every fold lags its multiply state by one cycle.
module ka22_accum
  import ka_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  ka_state_e         state,
  input  logic [KP_W-1:0]   kp,
  input  logic              clear,
  output logic [PROD_W-1:0] acc
);

  ka_state_e         fold_state;
  logic [KP_W-1:0]   fold_kp;
  logic [PROD_W-1:0] kp_ext;
  logic [PROD_W-1:0] fold_term;

`ifdef KA22_OUTREG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fold_state <= IDLE;
      fold_kp    <= '0;
    end else begin
      fold_state <= state;
      fold_kp    <= kp;
    end
  end
`else
  always_comb begin
    fold_state = state;
    fold_kp    = kp;
  end
`endif

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    kp_ext    = {{(PROD_W-KP_W){1'b0}}, fold_kp};
    fold_term = '0;
    case (fold_state)
      MUL_LO:  fold_term = kp_ext ^ (kp_ext << HALF_W);
      MUL_HI:  fold_term = (kp_ext << HALF_W) ^ (kp_ext << (2 * HALF_W));
      MUL_MID: fold_term = kp_ext << HALF_W;
      default: fold_term = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clear) acc <= '0;
    else            acc <= acc ^ fold_term;
  end

endmodule

// File: rtl/ka_22bit_seq.sv
// Sequential 22x22-bit carry-less Karatsuba multiplier sharing one KA_11bit over
// three cycles. Define KA22_OUTREG_EN to register the core output (one extra cycle).
module ka_22bit_seq
  import ka_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] y
);

  ka_state_e         state, state_next;
  logic [OP_W-1:0]   a_q, b_q;
  logic [HALF_W-1:0] ka_a, ka_b;
  logic [KP_W-1:0]   kp;
  logic [PROD_W-1:0] acc;
  logic              accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  // Gating by DONE guarantees a partially folded acc is never visible.
  assign y         = out_valid ? acc : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the operand registers are plain flops, so they are reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = MUL_LO;
      MUL_LO:    state_next = MUL_HI;
      MUL_HI:    state_next = MUL_MID;
`ifdef KA22_OUTREG_EN
      MUL_MID:   state_next = MUL_FLUSH;
      MUL_FLUSH: state_next = DONE;
`else
      MUL_MID:   state_next = DONE;
`endif
      DONE:      if (out_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Operands are zero outside the multiply states to keep the core from toggling.
  always_comb begin
    ka_a = '0;
    ka_b = '0;
    case (state)
      MUL_LO: begin
        ka_a = a_q[HALF_W-1:0];
        ka_b = b_q[HALF_W-1:0];
      end
      MUL_HI: begin
        ka_a = a_q[OP_W-1:HALF_W];
        ka_b = b_q[OP_W-1:HALF_W];
      end
      MUL_MID: begin
        ka_a = a_q[HALF_W-1:0] ^ a_q[OP_W-1:HALF_W];
        ka_b = b_q[HALF_W-1:0] ^ b_q[OP_W-1:HALF_W];
      end
      default: begin
        ka_a = '0;
        ka_b = '0;
      end
    endcase
  end

  KA_11bit u_ka (
    .a (ka_a),
    .b (ka_b),
    .p (kp)
  );

  ka22_accum u_accum (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .kp    (kp),
    .clear (accept),
    .acc   (acc)
  );

endmodule
